icache_read_arbiter: RTL and testbench

- Two-requester arbiter that shares the single AR/R read port of the instruction cache.
- Requester 0 is the fetch unit; requester 1 is the prefetcher/redirect path.
- One transaction is outstanding at a time: grant, forward the address, route read beats back to the winner, release on the last beat.
- It also checks the beat count against arlen and flags protocol errors.

---
 rtl/icache_read_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_icache_read_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_read_arbiter.sv
// Two-requester arbiter in front of the instruction cache AR/R read port.
// Holds one transaction at a time: grant, forward the address, route read
// beats back to the owner and release on the last beat. The beat count is
// checked against the latched arlen; any mismatch raises a sticky err.
module icache_read_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [1:0]        m0_arburst,
  input  logic [2:0]        m0_arsize,
  input  logic [7:0]        m0_arlen,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [1:0]        m1_arburst,
  input  logic [2:0]        m1_arsize,
  input  logic [7:0]        m1_arlen,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  input  logic              m1_rready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [1:0]        s_arburst,
  output logic [2:0]        s_arsize,
  output logic [7:0]        s_arlen,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic              grant_id,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              grant_id_q, grant_id_d;
  logic              err_q, err_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [7:0]        arlen_q, arlen_d;

  logic win_s;
  logic hs_s;
  logic beat_s;
  logic fwd_s;

  // Pick the winner among valid requesters (tie: fixed m0 or round-robin pointer)
  always_comb begin
    win_s = 1'b0;
    if (m0_arvalid && m1_arvalid) begin
      win_s = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr_q;
    end else if (m1_arvalid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Handshakes and beat routing; everything is forced quiet while rst is high
  always_comb begin
    m0_arready = !rst && (state_q == S_IDLE) && m0_arvalid && !win_s;
    m1_arready = !rst && (state_q == S_IDLE) && m1_arvalid && win_s;
    hs_s       = m0_arready || m1_arready;
    fwd_s      = !rst && (state_q == S_DATA);
    s_rready   = fwd_s && (grant_id_q ? m1_rready : m0_rready);
    beat_s     = s_rvalid && s_rready;
    m0_rvalid  = fwd_s && !grant_id_q && s_rvalid;
    m1_rvalid  = fwd_s && grant_id_q && s_rvalid;
    m0_rlast   = fwd_s && !grant_id_q && s_rlast;
    m1_rlast   = fwd_s && grant_id_q && s_rlast;
    m0_rdata   = (fwd_s && !grant_id_q) ? s_rdata : '0;
    m1_rdata   = (fwd_s && grant_id_q) ? s_rdata : '0;
  end

  // Next-state logic for the transaction FSM, request latch and beat checker
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    err_d      = err_q;
    beat_cnt_d = beat_cnt_q;
    araddr_d   = araddr_q;
    arburst_d  = arburst_q;
    arsize_d   = arsize_q;
    arlen_d    = arlen_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          araddr_d   = win_s ? m1_araddr  : m0_araddr;
          arburst_d  = win_s ? m1_arburst : m0_arburst;
          arsize_d   = win_s ? m1_arsize  : m0_arsize;
          arlen_d    = win_s ? m1_arlen   : m0_arlen;
          grant_id_d = win_s;
          beat_cnt_d = 8'd0;
          state_d    = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (s_arready) begin
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (beat_s) begin
          // beat_cnt counts beats already taken, so the last beat sees arlen
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (s_rlast) begin
            if (beat_cnt_q != arlen_q) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (FIXED_PRIO == 0) begin
              rr_ptr_d = ~grant_id_q;
            end else begin
              rr_ptr_d = rr_ptr_q;
            end
            state_d = S_IDLE;
          end else if (beat_cnt_q == arlen_q) begin
            // overrun: more beats than requested (also covers an 8-bit wrap)
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset abandons any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      grant_id_q <= 1'b0;
      err_q      <= 1'b0;
      beat_cnt_q <= 8'd0;
      araddr_q   <= '0;
      arburst_q  <= 2'd0;
      arsize_q   <= 3'd0;
      arlen_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      araddr_q   <= araddr_d;
      arburst_q  <= arburst_d;
      arsize_q   <= arsize_d;
      arlen_q    <= arlen_d;
    end
  end

  assign s_arvalid = !rst && (state_q == S_ADDR);
  assign s_araddr  = araddr_q;
  assign s_arburst = arburst_q;
  assign s_arsize  = arsize_q;
  assign s_arlen   = arlen_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_icache_read_arbiter.sv
// Directed bench for icache_read_arbiter. A round-robin and a fixed-priority
// instance share every input; a table of arbitration rounds checks grant order
// on both, then hand-written sequences cover latency, long bursts,
// backpressure, beat-count errors and reset mid-transaction.
module tb_icache_read_arbiter;

  logic        clk, rst;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic [31:0] m0_araddr, m1_araddr;
  logic [1:0]  m0_arburst, m1_arburst;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [7:0]  m0_arlen, m1_arlen;
  logic        s_arready, s_rvalid, s_rlast;
  logic [63:0] s_rdata;

  logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
  logic [63:0] m0_rdata, m1_rdata;
  logic        s_arvalid, s_rready, grant_id, busy, err;
  logic [31:0] s_araddr;
  logic [1:0]  s_arburst;
  logic [2:0]  s_arsize;
  logic [7:0]  s_arlen;

  logic        f_m0_arready, f_m0_rvalid, f_m0_rlast, f_m1_arready, f_m1_rvalid, f_m1_rlast;
  logic [63:0] f_m0_rdata, f_m1_rdata;
  logic        f_s_arvalid, f_s_rready, f_grant_id, f_busy, f_err;
  logic [31:0] f_s_araddr;
  logic [1:0]  f_s_arburst;
  logic [2:0]  f_s_arsize;
  logic [7:0]  f_s_arlen;

  int total = 0;
  int bad   = 0;

  icache_read_arbiter #(.FIXED_PRIO(0), .ADDR_W(32), .DATA_W(64)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arburst(m0_arburst),
    .m0_arsize(m0_arsize), .m0_arlen(m0_arlen), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arburst(m1_arburst),
    .m1_arsize(m1_arsize), .m1_arlen(m1_arlen), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arburst(s_arburst),
    .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  icache_read_arbiter #(.FIXED_PRIO(1), .ADDR_W(32), .DATA_W(64)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arburst(m0_arburst),
    .m0_arsize(m0_arsize), .m0_arlen(m0_arlen), .m0_arready(f_m0_arready),
    .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_rlast(f_m0_rlast), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arburst(m1_arburst),
    .m1_arsize(m1_arsize), .m1_arlen(m1_arlen), .m1_arready(f_m1_arready),
    .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_rlast(f_m1_rlast), .m1_rready(m1_rready),
    .s_arvalid(f_s_arvalid), .s_araddr(f_s_araddr), .s_arburst(f_s_arburst),
    .s_arsize(f_s_arsize), .s_arlen(f_s_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rready(f_s_rready),
    .grant_id(f_grant_id), .busy(f_busy), .err(f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v0;
    logic v1;
    logic gid_rr;
    logic gid_fp;
  } round_t;

  round_t rounds[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from requester m while in IDLE; ends in DATA
  task automatic do_req(input logic m, input logic [31:0] addr, input logic [7:0] len);
    m0_arvalid = !m;
    m1_arvalid = m;
    if (m) begin
      m1_araddr = addr;
      m1_arlen  = len;
    end else begin
      m0_araddr = addr;
      m0_arlen  = len;
    end
    #1;
    chk("arready_own", m ? m1_arready : m0_arready, 1'b1);
    chk("s_arvalid_lat0", s_arvalid, 1'b0);
    tick();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    #1;
    chk("s_arvalid", s_arvalid, 1'b1);
    chk("s_araddr", s_araddr, addr);
    chk("s_arlen", s_arlen, len);
    chk("grant_id", grant_id, m);
    tick();
  endtask

  // Present one cache beat to owner m and let it be taken on the next edge
  task automatic beat(input logic [63:0] d, input logic last, input logic m);
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rlast  = last;
    #1;
    chk("rvalid_own", m ? m1_rvalid : m0_rvalid, 1'b1);
    chk("rdata_own", m ? m1_rdata : m0_rdata, d);
    chk("rlast_own", m ? m1_rlast : m0_rlast, last);
    chk("rvalid_other", m ? m0_rvalid : m1_rvalid, 1'b0);
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    rounds[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
    rounds[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    rounds[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
    rounds[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    rounds[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    rounds[5] = '{1'b1, 1'b1, 1'b0, 1'b0};
    rounds[6] = '{1'b1, 1'b0, 1'b0, 1'b0};
    rounds[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 32'h20; m0_arburst = 2'd1; m0_arsize = 3'd3; m0_arlen = 8'd0;
    m1_arvalid = 1'b0; m1_araddr = 32'h40; m1_arburst = 2'd2; m1_arsize = 3'd2; m1_arlen = 8'd0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = 64'd0;

    // reset state and gating
    tick();
    tick();
    chk("rst_arready", m0_arready, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    m0_arvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_s_araddr", s_araddr, 32'h0);
    chk("rst_s_arlen", s_arlen, 8'd0);
    tick();

    // arbitration rounds on both instances
    for (int i = 0; i < 8; i++) begin
      m0_arvalid = rounds[i].v0;
      m1_arvalid = rounds[i].v1;
      #1;
      chk("rr_arready", {m1_arready, m0_arready}, rounds[i].gid_rr ? 2'b10 : 2'b01);
      chk("fp_arready", {f_m1_arready, f_m0_arready}, rounds[i].gid_fp ? 2'b10 : 2'b01);
      tick();
      m0_arvalid = 1'b0;
      m1_arvalid = 1'b0;
      #1;
      chk("rr_grant", grant_id, rounds[i].gid_rr);
      chk("fp_grant", f_grant_id, rounds[i].gid_fp);
      chk("rr_araddr", s_araddr, rounds[i].gid_rr ? 32'h40 : 32'h20);
      chk("fp_araddr", f_s_araddr, rounds[i].gid_fp ? 32'h40 : 32'h20);
      chk("rr_arburst", s_arburst, rounds[i].gid_rr ? 2'd2 : 2'd1);
      tick();
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h1000 + 64'(i);
      #1;
      chk("rr_rdata", rounds[i].gid_rr ? m1_rdata : m0_rdata, 64'h1000 + 64'(i));
      chk("rr_rvalid_other", rounds[i].gid_rr ? m0_rvalid : m1_rvalid, 1'b0);
      chk("fp_rvalid", rounds[i].gid_fp ? f_m1_rvalid : f_m0_rvalid, 1'b1);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      chk("round_idle", busy, 1'b0);
      chk("round_err", err, 1'b0);
    end

    // single request with 1-cycle request latency
    m0_arburst = 2'd1; m0_arsize = 3'd3;
    do_req(1'b0, 32'h10, 8'd0);
    chk("single_arburst", s_arburst, 2'd1);
    chk("single_arsize", s_arsize, 3'd3);
    chk("single_s_rready", s_rready, 1'b1);
    beat(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0);
    #1;
    chk("single_idle", busy, 1'b0);
    chk("single_err", err, 1'b0);
    chk("single_m1_rvalid", m1_rvalid, 1'b0);

    // 256-beat burst: no false error from the 8-bit counter
    do_req(1'b0, 32'h100, 8'd255);
    for (int i = 0; i < 256; i++) begin
      beat(64'(i) * 64'h0101, (i == 255), 1'b0);
      if (i == 254) chk("long_no_early_err", err, 1'b0);
    end
    #1;
    chk("long_idle", busy, 1'b0);
    chk("long_err", err, 1'b0);

    // backpressure from m1
    do_req(1'b1, 32'h80, 8'd0);
    m1_rready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s_rready", s_rready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    m1_rready = 1'b1;
    #1;
    chk("bp_s_rready_up", s_rready, 1'b1);
    chk("bp_rdata", m1_rdata, 64'h5555_6666_7777_8888);
    chk("bp_rvalid", m1_rvalid, 1'b1);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("bp_idle", busy, 1'b0);
    chk("bp_err", err, 1'b0);

    // rlast arrives too early: arlen=1 but one beat
    do_req(1'b0, 32'h200, 8'd1);
    beat(64'h1, 1'b1, 1'b0);
    #1;
    chk("early_err", err, 1'b1);
    chk("early_idle", busy, 1'b0);
    // a good transaction afterwards leaves err sticky
    do_req(1'b0, 32'h300, 8'd0);
    beat(64'h2, 1'b1, 1'b0);
    #1;
    chk("sticky_err", err, 1'b1);

    // reset in DATA; rr pointer currently favours m1
    do_req(1'b0, 32'h400, 8'd0);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h3;
    rst = 1'b1;
    #1;
    chk("rstd_s_rready", s_rready, 1'b0);
    chk("rstd_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstd_busy", busy, 1'b0);
    chk("rstd_err", err, 1'b0);
    chk("rstd_s_arvalid", s_arvalid, 1'b0);
    chk("rstd_rvalids", {m1_rvalid, m0_rvalid}, 2'b00);
    chk("rstd_s_rready2", s_rready, 1'b0);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    #1;
    chk("rstd_rrptr", {m1_arready, m0_arready}, 2'b01);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    #1;
    do_req(1'b1, 32'h500, 8'd0);
    beat(64'h4, 1'b1, 1'b1);
    #1;
    chk("fresh_idle", busy, 1'b0);
    chk("fresh_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
